// File: rtl/perf_pkg.sv
// Shared types and read-address map for the performance-counter unit.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } perf_state_t;

    localparam int ADDR_CYCLE    = 0;
    localparam int ADDR_EVT_BASE = 1;

    // The overflow-flag word sits just past the last event channel.
    function automatic int addr_ovf(input int num_evt);
        return num_evt + 1;
    endfunction

endpackage

// File: rtl/perf_cnt_slice.sv
// One CNT_W counter with a sticky overflow flag.
// Wraps by default; saturates at all-ones when PERF_SATURATE_EN is defined.
module perf_cnt_slice #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    input  logic             i_frz,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_max;

    assign w_max = &r_cnt;
    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_inc && !i_frz) begin
            if (w_max)
                r_ovf <= 1'b1;
`ifdef PERF_SATURATE_EN
            if (!w_max)
                r_cnt <= r_cnt + CNT_W'(1);
`else
            r_cnt <= r_cnt + CNT_W'(1);
`endif
        end
    end

endmodule

// File: rtl/perf_event_counters.sv
// Cycle + NUM_EVT event counters with start/halt/clear control and a registered read port.
// Build option PERF_SATURATE_EN makes counters saturate instead of wrap.
module perf_event_counters
    import perf_pkg::*;
#(
    parameter int NUM_EVT = 5,
    parameter int CNT_W   = 32,
    localparam int AW     = $clog2(NUM_EVT + 2)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_halt,
    input  logic               i_clear,
    input  logic [NUM_EVT-1:0] i_evt,
    input  logic               i_rd_en,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [CNT_W-1:0]   o_rd_data,
    output logic               o_rd_valid,
    output logic               o_running,
    output logic               o_halted,
    output logic [NUM_EVT:0]   o_ovf
);

    localparam int ADDR_OVF = addr_ovf(NUM_EVT);

    perf_state_t                  r_state;
    logic                         r_running;
    logic                         r_halted;
    logic [CNT_W-1:0]             r_rd_data;
    logic                         r_rd_valid;
    logic [NUM_EVT:0][CNT_W-1:0]  w_cnt;
    logic [NUM_EVT:0]             w_ovf;
    logic [NUM_EVT:0]             w_inc;
    logic                         w_frz;
    logic [CNT_W-1:0]             w_rd_mux;

    // Halt has priority over start, so both together in IDLE stay in IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else if (i_clear) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && !i_halt) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_halt) begin
                        r_state   <= HALTED;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                    end
                end
                HALTED: ;
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    // The halt cycle itself still sees RUN, so it is counted before freezing.
    assign w_frz = (r_state != RUN);
    assign w_inc = {i_evt, 1'b1};

    genvar g;
    for (g = 0; g <= NUM_EVT; g++) begin : g_slice
        perf_cnt_slice #(.CNT_W(CNT_W)) u_slice (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_inc (w_inc[g]),
            .i_clr (i_clear),
            .i_frz (w_frz),
            .o_cnt (w_cnt[g]),
            .o_ovf (w_ovf[g])
        );
    end

    always_comb begin
        w_rd_mux = '0;
        if (i_rd_addr == AW'(ADDR_CYCLE))
            w_rd_mux = w_cnt[0];
        for (int i = 0; i < NUM_EVT; i++)
            if (i_rd_addr == AW'(ADDR_EVT_BASE + i))
                w_rd_mux = w_cnt[i+1];
        if (i_rd_addr == AW'(ADDR_OVF)) begin
            w_rd_mux = '0;
            for (int i = 0; i <= NUM_EVT && i < CNT_W; i++)
                w_rd_mux[i] = w_ovf[i];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (i_rd_en) begin
            r_rd_data  <= w_rd_mux;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_running  = r_running;
    assign o_halted   = r_halted;
    assign o_ovf      = w_ovf;

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters: a 32-bit instance and an 8-bit instance share stimulus.
module tb_perf_event_counters;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, halt = 1'b0, clear = 1'b0, rd_en = 1'b0;
    logic [4:0]  evt = '0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid, running, halted;
    logic [5:0]  ovf;
    logic [7:0]  rd_data8;
    logic        rd_valid8, running8, halted8;
    logic [5:0]  ovf8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    perf_event_counters #(.NUM_EVT(5), .CNT_W(32)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt(halt), .i_clear(clear),
        .i_evt(evt), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_running(running),
        .o_halted(halted), .o_ovf(ovf)
    );

    perf_event_counters #(.NUM_EVT(5), .CNT_W(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt(halt), .i_clear(clear),
        .i_evt(evt), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data8), .o_rd_valid(rd_valid8), .o_running(running8),
        .o_halted(halted8), .o_ovf(ovf8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_addr = a;
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic restart();
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #9;
        n_vec++;
        if ({rd_valid, running, halted, ovf, rd_data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b run=%b hlt=%b ovf=%b data=%0d, want all 0",
                     rd_valid, running, halted, ovf, rd_data);
        end
        #2 rst = 1'b0;
        tick();
        rd(3'd0);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_cycle_cnt: got %0d valid=%b, want 0 valid=1", rd_data, rd_valid);
        end
    endtask

    logic [31:0] exp1 [7] = '{32'd10, 32'd10, 32'd0, 32'd0, 32'd4, 32'd0, 32'd0};

    task automatic check_scn1(input string tag);
        for (int a = 0; a < 7; a++) begin
            rd(3'(a));
            n_vec++;
            if (rd_valid !== 1'b1 || rd_data !== exp1[a]) begin
                n_err++;
                $display("FAIL %s addr%0d: got %0d valid=%b, want %0d valid=1", tag, a, rd_data, rd_valid, exp1[a]);
            end
        end
        n_vec++;
        if (halted !== 1'b1 || running !== 1'b0 || ovf !== 6'd0) begin
            n_err++;
            $display("FAIL %s state: got hlt=%b run=%b ovf=%b, want hlt=1 run=0 ovf=0", tag, halted, running, ovf);
        end
    endtask

    task automatic test_basic();
        restart();
        for (int c = 1; c <= 10; c++) begin
            evt  = {1'b0, (c <= 4), 3'b001};
            halt = (c == 10);
            tick();
        end
        evt = '0; halt = 1'b0;
        check_scn1("basic");
    endtask

    task automatic test_freeze();
        start = 1'b1; tick(); start = 1'b0;
        evt = 5'b11111;
        repeat (20) tick();
        evt = '0;
        check_scn1("freeze");
    endtask

    task automatic test_clear_priority();
        restart();
        evt = 5'b00001;
        repeat (5) tick();
        clear = 1'b1; halt = 1'b1; rd_addr = 3'd0; rd_en = 1'b1;
        tick();
        clear = 1'b0; halt = 1'b0; rd_en = 1'b0;
        n_vec++;
        if (rd_data !== 32'd5 || rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL clear_read_preclear: got %0d valid=%b, want 5 valid=1", rd_data, rd_valid);
        end
        n_vec++;
        if (running !== 1'b0 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL clear_halt_state: got run=%b hlt=%b, want 0/0", running, halted);
        end
        for (int a = 0; a < 2; a++) begin
            rd(3'(a));
            n_vec++;
            if (rd_data !== 32'd0) begin
                n_err++;
                $display("FAIL clear_cnt addr%0d: got %0d, want 0", a, rd_data);
            end
        end
        start = 1'b1; halt = 1'b1; tick(); start = 1'b0; halt = 1'b0;
        evt = 5'b11111; repeat (3) tick(); evt = '0;
        n_vec++;
        if (running !== 1'b0 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL start_halt_idle: got run=%b hlt=%b, want 0/0", running, halted);
        end
        rd(3'd1);
        n_vec++;
        if (rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL idle_evt_ignored: got %0d, want 0", rd_data);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_v;
`ifdef PERF_SATURATE_EN
        exp_v = 8'hFF;
`else
        exp_v = 8'h01;
`endif
        restart();
        evt = 5'b00010;
        repeat (256) tick();
        halt = 1'b1; tick(); halt = 1'b0;
        evt = '0;
        rd(3'd0);
        n_vec++;
        if (rd_data8 !== exp_v) begin
            n_err++;
            $display("FAIL wrap_cycle: got %0h, want %0h", rd_data8, exp_v);
        end
        rd(3'd2);
        n_vec++;
        if (rd_data8 !== exp_v) begin
            n_err++;
            $display("FAIL wrap_ch1: got %0h, want %0h", rd_data8, exp_v);
        end
        rd(3'd6);
        n_vec++;
        if (ovf8 !== 6'b000101 || rd_data8 !== 8'h05) begin
            n_err++;
            $display("FAIL wrap_ovf: got port=%b read=%0h, want 000101/05", ovf8, rd_data8);
        end
        n_vec++;
        if (ovf !== 6'd0 || rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL wide_no_ovf: got port=%b read=%0h, want 0/0", ovf, rd_data);
        end
    endtask

    task automatic test_read_timing();
        restart();
        repeat (7) tick();
        rd(3'd0);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd7 || running !== 1'b1) begin
            n_err++;
            $display("FAIL rd_latency: got %0d valid=%b run=%b, want 7 valid=1 run=1", rd_data, rd_valid, running);
        end
        tick();
        n_vec++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd7) begin
            n_err++;
            $display("FAIL rd_idle_hold: got %0d valid=%b, want 7 valid=0", rd_data, rd_valid);
        end
        rd(3'd7);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL rd_reserved: got %0d valid=%b, want 0 valid=1", rd_data, rd_valid);
        end
    endtask

    task automatic test_async_reset();
        restart();
        repeat (50) tick();
        rd_addr = 3'd0; rd_en = 1'b1;
        tick();
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd50) begin
            n_err++;
            $display("FAIL pre_rst_read: got %0d valid=%b, want 50 valid=1", rd_data, rd_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd0 || running !== 1'b0 || halted !== 1'b0 || ovf !== 6'd0) begin
            n_err++;
            $display("FAIL async_rst: got data=%0d valid=%b run=%b hlt=%b ovf=%b, want all 0",
                     rd_data, rd_valid, running, halted, ovf);
        end
        rd_en = 1'b0;
        #2 rst = 1'b0;
        tick(); tick();
        rd(3'd0);
        n_vec++;
        if (running !== 1'b0 || halted !== 1'b0 || rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL post_rst_idle: got run=%b hlt=%b cycle=%0d, want 0/0/0", running, halted, rd_data);
        end
    endtask

    task automatic test_halt_cycle();
        logic [5:0] pat;
        pat = 6'b110101;
        restart();
        for (int c = 0; c < 6; c++) begin
            evt  = {4'b0, pat[c]};
            halt = (c == 5);
            tick();
        end
        evt = '0; halt = 1'b0;
        rd(3'd1);
        n_vec++;
        if (rd_data !== 32'd4) begin
            n_err++;
            $display("FAIL halt_cycle_ch0: got %0d, want 4", rd_data);
        end
        rd(3'd0);
        n_vec++;
        if (rd_data !== 32'd6 || halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_cycle_cnt: got %0d hlt=%b, want 6 hlt=1", rd_data, halted);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_freeze();
        test_clear_priority();
        test_wrap();
        test_read_timing();
        test_async_reset();
        test_halt_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
